// File: rtl/wgt_load_ctrl_if.sv
// rtl/wgt_load_ctrl_if.sv - weight-memory read port between wgt_load_ctrl (master) and weight memory (slave)
interface wgt_load_ctrl_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rd_data;

    modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/wgt_load_ctrl.sv
// rtl/wgt_load_ctrl.sv - 3x3 filter weight-load sequencer; WGT_PREFETCH_EN enables shadow prefetch during WAIT
module wgt_load_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  num_filters_i,
    wgt_load_ctrl_if.master       mem,
    output logic [31:0]           wgt_word_o [2:0],
    output logic                  wgt_read_o,
    output logic                  wgt_loaded_o,
    input  logic                  next_filter_i,
    output logic [CNT_WIDTH-1:0]  filter_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, DONE} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [CNT_WIDTH-1:0]    num_q;
    logic [CNT_WIDTH-1:0]    idx_q;
    logic [1:0]              issue_q;     // next row to issue; 3 = all issued
    logic                    mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [1:0]              mem_row_q;
    logic                    rd_pend_q;   // read issued last cycle, data on bus now
    logic [1:0]              pend_row_q;
    logic [31:0]             wgt_word_q [2:0];
    logic                    wgt_read_q;
    logic                    wgt_loaded_q;
    logic                    busy_q;
    logic                    done_q;

    logic [CNT_WIDTH-1:0]    idx_nxt;
    logic [CNT_WIDTH-1:0]    iss_idx;
    logic [ADDR_WIDTH-1:0]   iss_addr;
    logic                    last_filter;
    logic                    cap_last;

    assign idx_nxt     = idx_q + CNT_WIDTH'(1);
    assign last_filter = (idx_q == num_q - CNT_WIDTH'(1));
    assign cap_last    = rd_pend_q && (pend_row_q == 2'd2);
    // Outside FETCH any issued read belongs to the following filter
    assign iss_idx     = (state_q == FETCH) ? idx_q : idx_nxt;
    assign iss_addr    = base_q + ADDR_WIDTH'(3) * ADDR_WIDTH'(iss_idx) + ADDR_WIDTH'(issue_q);

`ifdef WGT_PREFETCH_EN
    logic [31:0] shadow_q [2:0];
    logic [31:0] shadow_d [2:0];
    logic        pf_full_q;

    always_comb begin
        shadow_d = shadow_q;
        if (rd_pend_q) shadow_d[pend_row_q] = mem.mem_rd_data;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            issue_q      <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_row_q    <= '0;
            rd_pend_q    <= 1'b0;
            pend_row_q   <= '0;
            wgt_word_q   <= '{default: '0};
            wgt_read_q   <= 1'b0;
            wgt_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef WGT_PREFETCH_EN
            shadow_q     <= '{default: '0};
            pf_full_q    <= 1'b0;
`endif
        end else begin
            rd_pend_q   <= mem_rd_en_q;
            pend_row_q  <= mem_row_q;
            mem_rd_en_q <= 1'b0;
            wgt_read_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef WGT_PREFETCH_EN
            if (rd_pend_q) shadow_q[pend_row_q] <= mem.mem_rd_data;
            if (cap_last)  pf_full_q <= 1'b1;
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q <= base_addr_i;
                        num_q  <= num_filters_i;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (num_filters_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= base_addr_i;
                            mem_row_q   <= 2'd0;
                            issue_q     <= 2'd1;
                        end
                    end
                end
                FETCH: begin
                    if (issue_q != 2'd3) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= iss_addr;
                        mem_row_q   <= issue_q;
                        issue_q     <= issue_q + 2'd1;
                    end
                    if (rd_pend_q) wgt_word_q[pend_row_q] <= mem.mem_rd_data;
                    if (cap_last) begin
                        state_q    <= LOAD;
                        wgt_read_q <= 1'b1;
                        issue_q    <= 2'd0;
`ifdef WGT_PREFETCH_EN
                        // Rows fetched during WAIT live only in the shadow
                        wgt_word_q <= shadow_d;
                        pf_full_q  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    state_q      <= WAIT;
                    wgt_loaded_q <= 1'b1;
`ifdef WGT_PREFETCH_EN
                    pf_full_q <= 1'b0;
                    if (!last_filter) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= iss_addr;
                        mem_row_q   <= 2'd0;
                        issue_q     <= 2'd1;
                    end
`endif
                end
                WAIT: begin
                    if (next_filter_i) begin
                        wgt_loaded_q <= 1'b0;
                        if (last_filter) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_nxt;
`ifdef WGT_PREFETCH_EN
                            if (pf_full_q || cap_last) begin
                                state_q    <= LOAD;
                                wgt_read_q <= 1'b1;
                                wgt_word_q <= shadow_d;
                                issue_q    <= 2'd0;
                                pf_full_q  <= 1'b0;
                            end else begin
                                state_q <= FETCH;
                                if (issue_q != 2'd3) begin
                                    mem_rd_en_q <= 1'b1;
                                    mem_addr_q  <= iss_addr;
                                    mem_row_q   <= issue_q;
                                    issue_q     <= issue_q + 2'd1;
                                end
                            end
`else
                            state_q     <= FETCH;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= iss_addr;
                            mem_row_q   <= issue_q;
                            issue_q     <= issue_q + 2'd1;
`endif
                        end
                    end
`ifdef WGT_PREFETCH_EN
                    else if (!last_filter && issue_q != 2'd3) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= iss_addr;
                        mem_row_q   <= issue_q;
                        issue_q     <= issue_q + 2'd1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_rd_en = mem_rd_en_q;
    assign mem.mem_addr  = mem_addr_q;
    assign wgt_word_o    = wgt_word_q;
    assign wgt_read_o    = wgt_read_q;
    assign wgt_loaded_o  = wgt_loaded_q;
    assign filter_idx_o  = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule
